// File: rtl/alu_pkg.sv
// Shared constants and state encodings for the bitmask splitter.
package alu_pkg;
  localparam int WIDTH = 32;
  localparam int IDX_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_EMPTY = 2'd2
  } state_e;
endpackage

// File: rtl/bitmask_splitter_if.sv
// Mask-in / index-out stream bundle. The slave side is the splitter itself.
interface bitmask_splitter_if #(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int IDX_W = alu_pkg::IDX_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mask;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic             out_empty;
  logic [IDX_W:0]   out_count;

  modport slave (
    input  in_valid, in_mask, out_ready,
    output in_ready, out_valid, out_index, out_last, out_empty, out_count
  );

  modport master (
    output in_valid, in_mask, out_ready,
    input  in_ready, out_valid, out_index, out_last, out_empty, out_count
  );
endinterface

// File: rtl/lsb_priority_encoder.sv
// Combinational lowest-set-bit finder: one-hot "first hit" per bit, then
// each index bit is the OR of the hits whose position has that bit set.
module lsb_priority_encoder #(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int IDX_W = alu_pkg::IDX_W
) (
  input  logic [WIDTH-1:0] mask,
  output logic [IDX_W-1:0] index,
  output logic             found
);
  logic [WIDTH-1:0]             hit;
  logic [IDX_W-1:0][WIDTH-1:0]  col;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == 0) begin : g_lo
      assign hit[i] = mask[i];
    end else begin : g_hi
      assign hit[i] = mask[i] & ~(|mask[i-1:0]);
    end
    for (genvar b = 0; b < IDX_W; b++) begin : g_col
      assign col[b][i] = hit[i] & (((i >> b) & 1) == 1);
    end
  end

  for (genvar b = 0; b < IDX_W; b++) begin : g_idx
    assign index[b] = |col[b];
  end

  assign found = |mask;
endmodule

// File: rtl/bitmask_splitter.sv
// Splits an accepted bit mask into one beat per set bit, lowest index first,
// or a single "empty" beat for an all-zero mask. All outputs are registered.
module bitmask_splitter
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int IDX_W = alu_pkg::IDX_W
) (
  input  logic          clock,
  input  logic          reset_n,
  bitmask_splitter_if.slave bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_index_q, out_index_d;
  logic             out_last_q, out_last_d;
  logic             out_empty_q, out_empty_d;
  logic [IDX_W:0]   out_count_q, out_count_d;

  logic             accept, beat;
  logic [WIDTH-1:0] cand;
  logic [IDX_W-1:0] cand_idx;
  logic             cand_found, cand_single;

  // One encoder serves both paths: the freshly accepted mask, or the
  // remaining mask with its lowest bit already cleared for the next beat.
  assign accept      = (state_q == ST_IDLE) && in_ready_q && bus.in_valid;
  assign beat        = out_valid_q && bus.out_ready;
  assign cand        = accept ? bus.in_mask
                              : (mask_q & (mask_q - {{(WIDTH-1){1'b0}}, 1'b1}));
  assign cand_single = ((cand & (cand - {{(WIDTH-1){1'b0}}, 1'b1})) == '0);

  lsb_priority_encoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc (
    .mask  (cand),
    .index (cand_idx),
    .found (cand_found)
  );

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    out_empty_d = out_empty_q;
    out_count_d = out_count_q;
    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (accept) begin
          mask_d      = cand;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          if (cand_found) begin
            state_d     = ST_EMIT;
            out_index_d = cand_idx;
            out_last_d  = cand_single;
            out_empty_d = 1'b0;
            out_count_d = {{IDX_W{1'b0}}, 1'b1};
          end else begin
            state_d     = ST_EMPTY;
            out_index_d = '0;
            out_last_d  = 1'b1;
            out_empty_d = 1'b1;
            out_count_d = '0;
          end
        end
      end
      ST_EMIT: begin
        if (beat) begin
          if (out_last_q) begin
            state_d     = ST_IDLE;
            mask_d      = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_index_d = '0;
            out_last_d  = 1'b0;
            out_count_d = '0;
          end else begin
            mask_d      = cand;
            out_index_d = cand_idx;
            out_last_d  = cand_single;
            out_count_d = out_count_q + {{IDX_W{1'b0}}, 1'b1};
          end
        end
      end
      ST_EMPTY: begin
        if (beat) begin
          state_d     = ST_IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          out_empty_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        mask_d     = '0;
        in_ready_d = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      out_empty_q <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      out_empty_q <= out_empty_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_index = out_index_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_empty = out_empty_q;
  assign bus.out_count = out_count_q;
endmodule

// File: doc/bitmask_splitter.md
BITMASK_SPLITTER -- requirements
Module: bitmask_splitter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: width of the accepted bit mask.
REQ-002 SHALL have parameter IDX_W, default 5: index width, equal to clog2(WIDTH).
REQ-003 SHALL have port clock, input, 1: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: in_mask is valid.
REQ-006 SHALL have port in_ready, output, 1: the block can accept a mask.
REQ-007 SHALL have port in_mask, input, WIDTH: merged bit mask, for example a bitwise OR result.
REQ-008 SHALL have port out_valid, output, 1: out_index is valid.
REQ-009 SHALL have port out_ready, input, 1: the consumer accepts the current beat.
REQ-010 SHALL have port out_index, output, IDX_W: position of the set bit being emitted.
REQ-011 SHALL have port out_last, output, 1: final beat for the current mask.
REQ-012 SHALL have port out_empty, output, 1: the accepted mask was all-zero.
REQ-013 SHALL have port out_count, output, IDX_W+1: 1-based ordinal of the current beat.

Function
REQ-014 SHALL implement the states IDLE, EMIT and EMPTY, and SHALL register all outputs.
REQ-015 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-016 When in_valid and in_ready are both 1, the block SHALL capture in_mask into a remaining-mask register.
REQ-017 After that capture, the block SHALL go to EMIT if the mask is non-zero, otherwise to EMPTY.
REQ-018 In EMIT and EMPTY, in_ready SHALL be 0; a new mask SHALL NOT be accepted while one is in progress.
REQ-019 In EMIT, out_valid SHALL be 1 and out_index SHALL be the lowest set bit of the remaining mask.
REQ-020 In EMIT, out_last SHALL be 1 exactly when the remaining mask has one bit set.
REQ-021 Indices SHALL be emitted in ascending order.
REQ-022 On an EMIT handshake (out_valid and out_ready), the emitted bit SHALL be cleared and out_count SHALL increment.
REQ-023 If the EMIT handshake carries out_last, the block SHALL return to IDLE on the next edge.
REQ-024 In EMPTY, the block SHALL present one beat: out_valid=1, out_empty=1, out_last=1, out_index=0, out_count=0.
REQ-025 On the EMPTY handshake, the block SHALL return to IDLE.
REQ-026 The first beat SHALL be presented on the cycle after input acceptance (latency 1).
REQ-027 While out_ready=0, all outputs SHALL hold stable (no beat dropped or altered).
REQ-028 Throughput SHALL be one index per cycle when out_ready is held at 1.
REQ-029 in_ready SHALL rise on the cycle after the final handshake; back-to-back accept-on-last is not supported.
REQ-030 A mask of 0xFFFF_FFFF SHALL produce exactly 32 beats with out_count running 1..32, so out_count SHALL NOT wrap.
REQ-031 in_valid asserted outside IDLE SHALL be ignored; the driver holds in_mask until acceptance.

Reset
REQ-032 While reset_n=0, the block SHALL force state IDLE, remaining mask 0, and outputs in_ready=0, out_valid=0, out_index=0, out_last=0, out_empty=0, out_count=0, independent of clock.
REQ-033 Reset asserted mid-EMIT SHALL discard the mask in progress; no further beats SHALL appear.
REQ-034 in_ready SHALL become 1 on the first clock edge after reset_n deasserts.

Structure
REQ-035 WIDTH, IDX_W and the state encodings SHALL live in the shared ALU constants package, alu_pkg.
REQ-036 The lowest-set-bit search SHALL be a combinational sub-module lsb_priority_encoder (WIDTH->IDX_W, plus a found flag), built with a generate loop.
REQ-037 The one-bit-remaining test SHALL be computed as (mask & (mask-1))==0, with no separate popcount.

Verification
REQ-038 SHALL test: mask 0x8000_0011 with out_ready=1 -> indices 0,4,31 on consecutive cycles; out_count 1,2,3; out_last only on 31.
REQ-039 SHALL test: mask 0x0000_0000 -> one beat with out_empty=1, out_last=1, out_index=0; in_ready=1 the following cycle.
REQ-040 SHALL test: mask 0xFFFF_FFFF with out_ready toggling every cycle -> 32 beats, indices 0..31, each held stable through its stall; out_count reaches 32.
REQ-041 SHALL test: mask 0x0000_00F0, with reset_n pulsed low after beats 4 and 5 -> outputs cleared immediately; after release, mask 0x0000_0001 gives a single beat, index 0, out_last=1.
REQ-042 SHALL test: in_valid held at 1 with a new mask 0x0000_0400 during EMIT of 0x0000_0003 -> new mask not taken until IDLE, then index 10 is emitted after indices 0 and 1.
